// File: rtl/vm_pkg.sv
// Shared definitions for the change dispenser: coin encodings, values in quarters, FSM states.
package vm_pkg;

  typedef enum logic [1:0] {
    COIN_1   = 2'd0,
    COIN_05  = 2'd1,
    COIN_025 = 2'd2
  } coin_e;

  localparam logic signed [15:0] VAL_1   = 16'sd4;
  localparam logic signed [15:0] VAL_05  = 16'sd2;
  localparam logic signed [15:0] VAL_025 = 16'sd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_DONE,
    ST_FAULT
  } state_e;

  function automatic logic signed [15:0] coin_value(input coin_e c);
    logic signed [15:0] v;
    case (c)
      COIN_1:  v = VAL_1;
      COIN_05: v = VAL_05;
      default: v = VAL_025;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

endpackage

// File: rtl/change_dispense_ctrl_if.sv
// Command, inventory, ejector handshake and status bundle of the change dispenser.
interface change_dispense_ctrl_if;
  logic               in_start;
  logic signed [15:0] in_change;
  logic [7:0]         in_inv_1;
  logic [7:0]         in_inv_05;
  logic [7:0]         in_inv_025;
  logic               in_eject_ack;
  logic               in_abort;

  logic               out_eject_req;
  logic [1:0]         out_eject_type;
  logic [7:0]         out_cnt_1;
  logic [7:0]         out_cnt_05;
  logic [7:0]         out_cnt_025;
  logic signed [15:0] out_remain;
  logic               out_busy;
  logic               out_done;
  logic               out_short;
  logic               out_fault;

  modport master (
    output in_start, in_change, in_inv_1, in_inv_05, in_inv_025, in_eject_ack, in_abort,
    input  out_eject_req, out_eject_type, out_cnt_1, out_cnt_05, out_cnt_025,
           out_remain, out_busy, out_done, out_short, out_fault
  );

  modport slave (
    input  in_start, in_change, in_inv_1, in_inv_05, in_inv_025, in_eject_ack, in_abort,
    output out_eject_req, out_eject_type, out_cnt_1, out_cnt_05, out_cnt_025,
           out_remain, out_busy, out_done, out_short, out_fault
  );
endinterface

// File: rtl/coin_select.sv
// Combinational greedy picker: largest coin not exceeding the amount owed that is still in stock.
module coin_select
  import vm_pkg::*;
(
  input  logic signed [15:0] remain_i,
  input  logic [7:0]         inv_1_i,
  input  logic [7:0]         inv_05_i,
  input  logic [7:0]         inv_025_i,
  output logic               vld_o,
  output coin_e              type_o
);

  always_comb begin
    vld_o  = 1'b0;
    type_o = COIN_1;
    if (remain_i >= VAL_1 && inv_1_i != 8'd0) begin
      vld_o  = 1'b1;
      type_o = COIN_1;
    end else if (remain_i >= VAL_05 && inv_05_i != 8'd0) begin
      vld_o  = 1'b1;
      type_o = COIN_05;
    end else if (remain_i >= VAL_025 && inv_025_i != 8'd0) begin
      vld_o  = 1'b1;
      type_o = COIN_025;
    end
  end

endmodule

// File: rtl/change_dispense_ctrl.sv
// Greedy change dispenser issuing one coin per ejector handshake; first eject_req 2 cycles after start,
// each coin costs ack wait + 1 select cycle; a missing ack for ACK_TIMEOUT cycles latches FAULT until reset.
module change_dispense_ctrl
  import vm_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input logic                   in_clka,
  input logic                   in_restart_n,
  change_dispense_ctrl_if.slave bus
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  state_e             state_q, state_d;
  logic signed [15:0] remain_q, remain_d;
  logic [7:0]         inv_1_q, inv_1_d, inv_05_q, inv_05_d, inv_025_q, inv_025_d;
  logic [7:0]         cnt_1_q, cnt_1_d, cnt_05_q, cnt_05_d, cnt_025_q, cnt_025_d;
  coin_e              type_q, type_d;
  logic               short_q, short_d;
  logic [TW-1:0]      tmo_q, tmo_d;

  logic               sel_vld;
  coin_e              sel_type;

  coin_select u_coin_select (
    .remain_i  (remain_q),
    .inv_1_i   (inv_1_q),
    .inv_05_i  (inv_05_q),
    .inv_025_i (inv_025_q),
    .vld_o     (sel_vld),
    .type_o    (sel_type)
  );

  always_ff @(posedge in_clka) begin
    if (!in_restart_n) begin
      state_q   <= ST_IDLE;
      remain_q  <= '0;
      inv_1_q   <= '0;
      inv_05_q  <= '0;
      inv_025_q <= '0;
      cnt_1_q   <= '0;
      cnt_05_q  <= '0;
      cnt_025_q <= '0;
      type_q    <= COIN_1;
      short_q   <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      inv_1_q   <= inv_1_d;
      inv_05_q  <= inv_05_d;
      inv_025_q <= inv_025_d;
      cnt_1_q   <= cnt_1_d;
      cnt_05_q  <= cnt_05_d;
      cnt_025_q <= cnt_025_d;
      type_q    <= type_d;
      short_q   <= short_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    remain_d  = remain_q;
    inv_1_d   = inv_1_q;
    inv_05_d  = inv_05_q;
    inv_025_d = inv_025_q;
    cnt_1_d   = cnt_1_q;
    cnt_05_d  = cnt_05_q;
    cnt_025_d = cnt_025_q;
    type_d    = type_q;
    short_d   = short_q;
    tmo_d     = tmo_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_start) begin
          inv_1_d   = bus.in_inv_1;
          inv_05_d  = bus.in_inv_05;
          inv_025_d = bus.in_inv_025;
          cnt_1_d   = '0;
          cnt_05_d  = '0;
          cnt_025_d = '0;
          short_d   = 1'b0;
          if (bus.in_change > 16'sd0) begin
            remain_d = bus.in_change;
            state_d  = ST_SELECT;
          end else begin
            remain_d = '0;
            state_d  = ST_DONE;
          end
        end
      end
      ST_SELECT: begin
        if (bus.in_abort) begin
          state_d = ST_IDLE;
        end else if (sel_vld) begin
          type_d  = sel_type;
          tmo_d   = '0;
          state_d = ST_REQ;
        end else begin
          short_d = (remain_q != 16'sd0);
          state_d = ST_DONE;
        end
      end
      ST_REQ: begin
        // An ack coincident with abort still counts the released coin.
        if (bus.in_eject_ack) begin
          remain_d = remain_q - coin_value(type_q);
          case (type_q)
            COIN_1: begin
              cnt_1_d = sat_inc(cnt_1_q);
              inv_1_d = inv_1_q - 8'd1;
            end
            COIN_05: begin
              cnt_05_d = sat_inc(cnt_05_q);
              inv_05_d = inv_05_q - 8'd1;
            end
            default: begin
              cnt_025_d = sat_inc(cnt_025_q);
              inv_025_d = inv_025_q - 8'd1;
            end
          endcase
          state_d = bus.in_abort ? ST_IDLE : ST_SELECT;
        end else if (bus.in_abort) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TW'(ACK_TIMEOUT - 1)) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign bus.out_eject_req  = (state_q == ST_REQ);
  assign bus.out_eject_type = type_q;
  assign bus.out_cnt_1      = cnt_1_q;
  assign bus.out_cnt_05     = cnt_05_q;
  assign bus.out_cnt_025    = cnt_025_q;
  assign bus.out_remain     = remain_q;
  assign bus.out_busy       = (state_q == ST_SELECT) || (state_q == ST_REQ);
  assign bus.out_done       = (state_q == ST_DONE);
  assign bus.out_short      = short_q;
  assign bus.out_fault      = (state_q == ST_FAULT);

endmodule

// File: tb/tb_change_dispense_ctrl.sv
// Bench for change_dispense_ctrl: directed scenarios plus randomized transactions against a greedy arithmetic model.
module tb_change_dispense_ctrl;

  logic in_clka = 1'b0;
  logic in_restart_n = 1'b0;
  always #5 in_clka = ~in_clka;

  change_dispense_ctrl_if bus ();

  change_dispense_ctrl #(.ACK_TIMEOUT(15)) dut (
    .in_clka      (in_clka),
    .in_restart_n (in_restart_n),
    .bus          (bus)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  int obs_types[$];
  int exp_types[$];
  int obs_done, obs_done_cyc, obs_lat, obs_short, obs_timeout;
  int exp_n1, exp_n05, exp_n025, exp_rem, exp_short;

  task automatic tick();
    @(posedge in_clka);
    #1;
  endtask

  task automatic do_reset();
    in_restart_n = 1'b0;
    repeat (2) tick();
    in_restart_n = 1'b1;
  endtask

  // Whole-transaction greedy outcome from plain division: all $1s first, then halves, then quarters.
  task automatic model_greedy(input int chg, input int a, input int b, input int c);
    int r;
    exp_types.delete();
    r = (chg > 0) ? chg : 0;
    exp_n1 = (a < r / 4) ? a : r / 4;
    r -= 4 * exp_n1;
    exp_n05 = (b < r / 2) ? b : r / 2;
    r -= 2 * exp_n05;
    exp_n025 = (c < r) ? c : r;
    r -= exp_n025;
    exp_rem = r;
    exp_short = (r > 0) ? 1 : 0;
    repeat (exp_n1) exp_types.push_back(0);
    repeat (exp_n05) exp_types.push_back(1);
    repeat (exp_n025) exp_types.push_back(2);
  endtask

  function automatic int qdiff();
    int n;
    n = (obs_types.size() > exp_types.size()) ? obs_types.size() - exp_types.size()
                                              : exp_types.size() - obs_types.size();
    for (int i = 0; i < obs_types.size() && i < exp_types.size(); i++)
      if (obs_types[i] != exp_types[i]) n++;
    return n;
  endfunction

  // Plays the ejector: acks each request after dmin..dmax cycles; aborts on ack number abort_on.
  task automatic drive_txn(input int chg, input int a, input int b, input int c,
                           input int dmin, input int dmax, input int abort_on, input bit spam);
    int cyc;
    int d;
    bit fin;
    obs_types.delete();
    obs_done = 0; obs_done_cyc = -1; obs_lat = -1; obs_short = 0; obs_timeout = 1;
    bus.in_change  = 16'(chg);
    bus.in_inv_1   = 8'(a);
    bus.in_inv_05  = 8'(b);
    bus.in_inv_025 = 8'(c);
    bus.in_start   = 1'b1;
    tick();
    bus.in_start = 1'b0;
    cyc = 1;
    fin = 1'b0;
    while (!fin && cyc < 3000) begin
      if (bus.out_done) begin
        obs_done = 1;
        obs_done_cyc = cyc;
        obs_short = int'(bus.out_short);
        tick();
        cyc++;
        if (bus.out_done) obs_done++;
        obs_timeout = 0;
        fin = 1'b1;
      end else if (!bus.out_busy) begin
        obs_timeout = 0;
        fin = 1'b1;
      end else begin
        bus.in_start = spam;
        if (spam) bus.in_change = 16'sd100;
        if (bus.out_eject_req) begin
          if (obs_lat < 0) obs_lat = cyc;
          obs_types.push_back(int'(bus.out_eject_type));
          d = $urandom_range(dmax, dmin);
          repeat (d) begin tick(); cyc++; end
          bus.in_eject_ack = 1'b1;
          bus.in_abort = (abort_on == obs_types.size());
          tick();
          cyc++;
          bus.in_eject_ack = 1'b0;
          bus.in_abort = 1'b0;
        end else begin
          tick();
          cyc++;
        end
        bus.in_start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++; if (bus.out_eject_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", bus.out_eject_req); else pass_cnt++;
    total_cnt++; if (bus.out_eject_type !== 2'd0) $display("FAIL reset_type got=%0d exp=0", bus.out_eject_type); else pass_cnt++;
    total_cnt++; if ({bus.out_cnt_1, bus.out_cnt_05, bus.out_cnt_025} !== 24'd0)
      $display("FAIL reset_cnts got=%0d/%0d/%0d exp=0/0/0", bus.out_cnt_1, bus.out_cnt_05, bus.out_cnt_025); else pass_cnt++;
    total_cnt++; if (bus.out_remain !== 16'sd0) $display("FAIL reset_remain got=%0d exp=0", bus.out_remain); else pass_cnt++;
    total_cnt++; if ({bus.out_busy, bus.out_done, bus.out_short, bus.out_fault} !== 4'b0000)
      $display("FAIL reset_status got=%b exp=0000", {bus.out_busy, bus.out_done, bus.out_short, bus.out_fault}); else pass_cnt++;
  endtask

  task automatic test_basic();
    exp_types.delete();
    exp_types.push_back(0); exp_types.push_back(1); exp_types.push_back(2);
    drive_txn(7, 20, 20, 20, 1, 1, -1, 1'b0);
    total_cnt++; if (obs_timeout !== 0) $display("FAIL basic_hang got=%0d exp=0", obs_timeout); else pass_cnt++;
    total_cnt++; if (qdiff() !== 0) $display("FAIL basic_types got_n=%0d exp_n=3 diffs=%0d", obs_types.size(), qdiff()); else pass_cnt++;
    total_cnt++; if (obs_lat !== 2) $display("FAIL basic_latency got=%0d exp=2", obs_lat); else pass_cnt++;
    total_cnt++; if ({bus.out_cnt_1, bus.out_cnt_05, bus.out_cnt_025} !== {8'd1, 8'd1, 8'd1})
      $display("FAIL basic_cnts got=%0d/%0d/%0d exp=1/1/1", bus.out_cnt_1, bus.out_cnt_05, bus.out_cnt_025); else pass_cnt++;
    total_cnt++; if (bus.out_remain !== 16'sd0) $display("FAIL basic_remain got=%0d exp=0", bus.out_remain); else pass_cnt++;
    total_cnt++; if (obs_done !== 1) $display("FAIL basic_done got=%0d exp=1", obs_done); else pass_cnt++;
    total_cnt++; if (obs_short !== 0) $display("FAIL basic_short got=%0d exp=0", obs_short); else pass_cnt++;
  endtask

  task automatic test_short();
    exp_types.delete();
    exp_types.push_back(0); exp_types.push_back(1); exp_types.push_back(1);
    drive_txn(10, 1, 2, 0, 0, 2, -1, 1'b0);
    total_cnt++; if (qdiff() !== 0) $display("FAIL short_types got_n=%0d exp_n=3 diffs=%0d", obs_types.size(), qdiff()); else pass_cnt++;
    total_cnt++; if (bus.out_remain !== 16'sd2) $display("FAIL short_remain got=%0d exp=2", bus.out_remain); else pass_cnt++;
    total_cnt++; if (obs_short !== 1 || obs_done !== 1)
      $display("FAIL short_flag got short=%0d done=%0d exp short=1 done=1", obs_short, obs_done); else pass_cnt++;
    total_cnt++; if (bus.out_short !== 1'b1) $display("FAIL short_held got=%b exp=1", bus.out_short); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int req_cycles;
    bus.in_change = 16'sd4; bus.in_inv_1 = 8'd5; bus.in_inv_05 = 8'd5; bus.in_inv_025 = 8'd5;
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    tick();
    req_cycles = 0;
    while (bus.out_eject_req && req_cycles < 100) begin
      req_cycles++;
      tick();
    end
    total_cnt++; if (req_cycles !== 15) $display("FAIL timeout_req_cycles got=%0d exp=15", req_cycles); else pass_cnt++;
    total_cnt++; if (bus.out_fault !== 1'b1) $display("FAIL timeout_fault got=%b exp=1", bus.out_fault); else pass_cnt++;
    bus.in_start = 1'b1;
    repeat (3) tick();
    bus.in_start = 1'b0;
    total_cnt++; if ({bus.out_fault, bus.out_eject_req, bus.out_busy} !== 3'b100)
      $display("FAIL timeout_sticky got fault/req/busy=%b exp=100", {bus.out_fault, bus.out_eject_req, bus.out_busy}); else pass_cnt++;
    total_cnt++; if (bus.out_cnt_1 !== 8'd0 || bus.out_remain !== 16'sd4)
      $display("FAIL timeout_frozen got cnt_1=%0d remain=%0d exp cnt_1=0 remain=4", bus.out_cnt_1, bus.out_remain); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_abort();
    drive_txn(8, 20, 20, 20, 0, 2, 1, 1'b0);
    total_cnt++; if (obs_types.size() !== 1) $display("FAIL abort_reqs got=%0d exp=1", obs_types.size()); else pass_cnt++;
    total_cnt++; if (bus.out_cnt_1 !== 8'd1 || bus.out_remain !== 16'sd4)
      $display("FAIL abort_state got cnt_1=%0d remain=%0d exp cnt_1=1 remain=4", bus.out_cnt_1, bus.out_remain); else pass_cnt++;
    total_cnt++; if (obs_done !== 0 || bus.out_busy !== 1'b0)
      $display("FAIL abort_idle got done=%0d busy=%b exp done=0 busy=0", obs_done, bus.out_busy); else pass_cnt++;
  endtask

  task automatic test_nonpositive();
    drive_txn(-3, 9, 9, 9, 0, 0, -1, 1'b0);
    total_cnt++; if (obs_done_cyc !== 1) $display("FAIL neg_done_cycle got=%0d exp=1", obs_done_cyc); else pass_cnt++;
    total_cnt++; if (obs_types.size() !== 0) $display("FAIL neg_no_req got=%0d exp=0", obs_types.size()); else pass_cnt++;
    total_cnt++; if (bus.out_remain !== 16'sd0) $display("FAIL neg_remain got=%0d exp=0", bus.out_remain); else pass_cnt++;
    exp_types.delete();
    exp_types.push_back(0); exp_types.push_back(2);
    drive_txn(5, 9, 9, 9, 0, 3, -1, 1'b1);
    total_cnt++; if (qdiff() !== 0 || bus.out_remain !== 16'sd0)
      $display("FAIL busy_start_ignored got_n=%0d remain=%0d exp_n=2 remain=0", obs_types.size(), bus.out_remain); else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    bus.in_change = 16'sd4; bus.in_inv_1 = 8'd5; bus.in_inv_05 = 8'd5; bus.in_inv_025 = 8'd5;
    bus.in_start = 1'b1;
    tick();
    bus.in_start = 1'b0;
    tick();
    total_cnt++; if (bus.out_eject_req !== 1'b1) $display("FAIL rst_req_before got=%b exp=1", bus.out_eject_req); else pass_cnt++;
    bus.in_eject_ack = 1'b1;
    in_restart_n = 1'b0;
    tick();
    bus.in_eject_ack = 1'b0;
    in_restart_n = 1'b1;
    total_cnt++; if ({bus.out_eject_req, bus.out_busy, bus.out_done, bus.out_fault} !== 4'b0000 ||
                     bus.out_cnt_1 !== 8'd0 || bus.out_remain !== 16'sd0)
      $display("FAIL rst_mid_req got req/busy/done/fault=%b cnt_1=%0d remain=%0d exp 0000 0 0",
               {bus.out_eject_req, bus.out_busy, bus.out_done, bus.out_fault}, bus.out_cnt_1, bus.out_remain);
    else pass_cnt++;
    exp_types.delete();
    exp_types.push_back(0); exp_types.push_back(1);
    drive_txn(6, 5, 5, 5, 0, 2, -1, 1'b0);
    total_cnt++; if (qdiff() !== 0 || obs_done !== 1 || bus.out_remain !== 16'sd0)
      $display("FAIL rst_restart got_n=%0d done=%0d remain=%0d exp_n=2 done=1 remain=0", obs_types.size(), obs_done, bus.out_remain);
    else pass_cnt++;
  endtask

  task automatic test_random_back_to_back();
    int chg, a, b, c;
    for (int t = 0; t < 25; t++) begin
      chg = $urandom_range(60, 1);
      a = $urandom_range(8, 0);
      b = $urandom_range(8, 0);
      c = $urandom_range(8, 0);
      model_greedy(chg, a, b, c);
      drive_txn(chg, a, b, c, 0, 3, -1, 1'($urandom_range(1, 0)));
      total_cnt++; if (obs_timeout !== 0 || obs_done !== 1)
        $display("FAIL rnd%0d_done got timeout=%0d done=%0d exp 0 1", t, obs_timeout, obs_done); else pass_cnt++;
      total_cnt++; if (qdiff() !== 0)
        $display("FAIL rnd%0d_types chg=%0d got_n=%0d exp_n=%0d diffs=%0d", t, chg, obs_types.size(), exp_types.size(), qdiff()); else pass_cnt++;
      total_cnt++; if (int'(bus.out_cnt_1) !== exp_n1 || int'(bus.out_cnt_05) !== exp_n05 || int'(bus.out_cnt_025) !== exp_n025)
        $display("FAIL rnd%0d_cnts got=%0d/%0d/%0d exp=%0d/%0d/%0d", t, bus.out_cnt_1, bus.out_cnt_05, bus.out_cnt_025,
                 exp_n1, exp_n05, exp_n025); else pass_cnt++;
      total_cnt++; if (int'(bus.out_remain) !== exp_rem || obs_short !== exp_short)
        $display("FAIL rnd%0d_remain got=%0d short=%0d exp=%0d short=%0d", t, bus.out_remain, obs_short, exp_rem, exp_short); else pass_cnt++;
      total_cnt++; if (obs_lat !== ((exp_types.size() > 0) ? 2 : -1))
        $display("FAIL rnd%0d_latency got=%0d exp=%0d", t, obs_lat, (exp_types.size() > 0) ? 2 : -1); else pass_cnt++;
    end
  endtask

  initial begin
    bus.in_start = 1'b0;
    bus.in_change = '0;
    bus.in_inv_1 = '0;
    bus.in_inv_05 = '0;
    bus.in_inv_025 = '0;
    bus.in_eject_ack = 1'b0;
    bus.in_abort = 1'b0;
    test_reset();
    test_basic();
    test_short();
    test_timeout();
    test_abort();
    test_nonpositive();
    test_reset_mid_req();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
